// File: rtl/hier_leaf_pkg.sv
// hier_leaf_pkg: shared defaults and helpers for the leaf FIFO stage.
//   LEAF_*_DEF  : default parameter values for instantiating parents.
//   clog2_plus1 : width needed to hold values 0..depth inclusive.
package hier_leaf_pkg;

    localparam int LEAF_WIDTH_DEF = 8;
    localparam int LEAF_DEPTH_DEF = 4;
    localparam int LEAF_CNT_W_DEF = 16;

    // Occupancy must represent DEPTH itself, hence depth+1 values.
    function automatic int clog2_plus1(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hier_leaf_ptr.sv
// hier_leaf_ptr: wrapping pointer register.
//   clk, rst : clock, async active-high reset
//   inc_i    : advance pointer by one (wraps at 2^PW)
//   clr_i    : synchronous clear to zero, wins over inc_i
//   ptr_o    : current pointer value
module hier_leaf_ptr #(
    parameter int PW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i)      ptr_d = '0;
        else if (inc_i) ptr_d = ptr_q + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/hier_leaf_fifo_stage.sv
// hier_leaf_fifo_stage: valid/ready FIFO leaf with occupancy, flush,
// wrapping transfer counter and sticky overflow flag.
//   clk, rst            : clock, async active-high reset
//   flush               : synchronous clear of contents (beats push/pop)
//   in_valid/in_ready   : producer handshake, in_data write word
//   out_valid/out_ready : consumer handshake, out_data head word
//   count               : current occupancy 0..DEPTH
//   xfer_cnt            : completed output transfers, wrapping
//   overflow            : sticky, in_valid seen while full
module hier_leaf_fifo_stage
    import hier_leaf_pkg::*;
#(
    parameter int WIDTH = LEAF_WIDTH_DEF,
    parameter int DEPTH = LEAF_DEPTH_DEF,
    parameter int CNT_W = LEAF_CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [clog2_plus1(DEPTH)-1:0] count,
    output logic [CNT_W-1:0]              xfer_cnt,
    output logic                          overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = clog2_plus1(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] xfer_q, xfer_d;
    logic             ovf_q, ovf_d;
    logic             push, pop, push_en, pop_en;

    // Full refuses input even if a pop is pending: no full-FIFO bypass.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    // Flush swallows this cycle's handshakes entirely.
    assign push_en   = push & ~flush;
    assign pop_en    = pop & ~flush;

    hier_leaf_ptr #(.PW(PW)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (pop_en),
        .clr_i (flush),
        .ptr_o (rd_ptr)
    );

    hier_leaf_ptr #(.PW(PW)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (push_en),
        .clr_i (flush),
        .ptr_o (wr_ptr)
    );

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({push_en, pop_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        xfer_d = xfer_q + CNT_W'(pop_en);
        ovf_d  = ovf_q | (in_valid & ~in_ready & ~flush);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            xfer_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            xfer_q  <= xfer_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is deliberately left unreset; out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr] <= in_data;
    end

    assign out_data = out_valid ? mem_q[rd_ptr] : '0;
    assign count    = count_q;
    assign xfer_cnt = xfer_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_hier_leaf_fifo_stage.sv
module tb_hier_leaf_fifo_stage;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [2:0]    count;
    logic [CW-1:0] xfer_cnt;
    logic          overflow;

    hier_leaf_fifo_stage #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .xfer_cnt  (xfer_cnt),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: expected FIFO contents, transfer count, sticky flag.
    logic [W-1:0] exp_q[$];
    int           exp_xfer = 0;
    bit           exp_ovf  = 1'b0;
    int           n_chk = 0;
    int           n_err = 0;
    bit           mon_en = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one ns after the driver updates inputs, DUT outputs still
    // reflect the last edge. Compare state, and retire the head word on a
    // handshake that will complete at the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                chk("count",     32'(count),     32'(exp_q.size()));
                chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
                chk("in_ready",  32'(in_ready),  32'(exp_q.size() != D));
                chk("xfer_cnt",  32'(xfer_cnt),  32'(exp_xfer));
                chk("overflow",  32'(overflow),  32'(exp_ovf));
                chk("out_data",  32'(out_data),  exp_q.size() != 0 ? 32'(exp_q[0]) : 32'h0);
                if (exp_q.size() != 0 && out_ready && !flush) begin
                    void'(exp_q.pop_front());
                    exp_xfer = (exp_xfer + 1) % (1 << CW);
                end
            end
        end
    end

    // Driver: issue one cycle of stimulus and record the expected word.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        int sz0;
        @(negedge clk);
        in_valid = v; in_data = d; out_ready = r; flush = f;
        sz0 = exp_q.size();
        #2;
        if (f) exp_q.delete();
        else if (v && sz0 != D) exp_q.push_back(d);
        if (v && sz0 == D && !f) exp_ovf = 1'b1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_xfer = 0;
        exp_ovf  = 1'b0;
    endtask

    task automatic sync_reset();
        @(negedge clk);
        in_valid = 0; out_ready = 0; flush = 0;
        #3 rst = 1'b1;
        model_reset();
        @(negedge clk);
        #3 rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] d;
        // Initial reset held across two edges.
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;

        // Fill with consumer stalled.
        d = 8'h11;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, d, 1'b0, 1'b0);
            d = d + 8'h11;
        end
        // Drain.
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Simultaneous push/pop at occupancy 2.
        cyc(1'b1, 8'hA0, 1'b0, 1'b0);
        cyc(1'b1, 8'hA1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'hB0 + 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Overflow: full FIFO offered 0x55, then flushed; flag must stay.
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Flush priority at occupancy 3, then 0x66 must come out next.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 1'b1, 1'b1);
        cyc(1'b1, 8'h66, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 19) == 0));

        // 17 pops from reset: xfer_cnt wraps to 1.
        sync_reset();
        cyc(1'b1, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk); #2;
        chk("xfer_wrap", 32'(xfer_cnt), 32'd1);
        chk("wrap_count", 32'(count), 32'd1);

        // Async reset pulse between edges with data in flight.
        cyc(1'b1, 8'h99, 1'b0, 1'b0);
        cyc(1'b1, 8'h9A, 1'b0, 1'b0);
        mon_en = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("arst_count",     32'(count),     32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        chk("arst_out_data",  32'(out_data),  32'd0);
        chk("arst_xfer",      32'(xfer_cnt),  32'd0);
        chk("arst_overflow",  32'(overflow),  32'd0);
        in_valid = 1'b0;
        model_reset();
        #1 rst = 1'b0;
        mon_en = 1'b1;
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk); #3;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/hier_leaf_fifo_stage.md
Name: hier_leaf_fifo_stage

Overview:
- Leaf-level buffering stage instantiated beneath the generated hierarchy nodes (the se9 level and below).
- It replaces the empty leaf modules and gives each hierarchy branch real sequential content: a valid/ready FIFO with occupancy reporting, flush and a wrapping transfer counter.
- It sits between a producer leaf and a consumer leaf, so sibling instances can be chained into a stream.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, number of FIFO entries; power of two, >=2.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of contents.
- in_valid  input  1  producer presents in_data.
- in_ready  output  1  stage can accept a word.
- in_data  input  WIDTH  write data.
- out_valid  output  1  head word available.
- out_ready  input  1  consumer accepts head word.
- out_data  output  WIDTH  head word.
- count  output  $clog2(DEPTH+1)  current occupancy.
- xfer_cnt  output  CNT_W  number of completed output transfers, wrapping.
- overflow  output  1  sticky flag: in_valid was asserted while the FIFO was full.

Behaviour:
- Reset (rst high, asynchronous):
  - pointers = 0, count = 0, xfer_cnt = 0, overflow = 0.
  - out_valid = 0, in_ready = 1.
  - out_data = 0, and the storage array is not reset.
- Push and pop conditions:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- in_ready = (count != DEPTH). There is no same-cycle bypass of a full FIFO; a full FIFO refuses input even when pop is asserted.
- out_valid = (count != 0).
- out_data = storage[rd_ptr], driven combinationally from registered state, so there is no glitch dependence on inputs.
- Latency: a word pushed in cycle N is visible on out_data with out_valid = 1 in cycle N+1 at the earliest. There is no combinational in-to-out path.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged, with write and read at independent slots.
- Empty with in_valid: the word is written, and out_valid rises in the next cycle.
- Full with out_ready: the pop occurs, and in_ready rises in the next cycle.
- Flush (synchronous):
  - next state: pointers = 0, count = 0.
  - flush overrides any push and pop in the same cycle; neither is counted.
  - xfer_cnt and overflow are not cleared by flush.
- xfer_cnt increments by 1 on each pop, wrapping from 2^CNT_W-1 to 0.
- overflow is set on any cycle with in_valid & !in_ready & !flush, and is cleared only by rst.
- Reset asserted mid-transfer: all state returns to reset values immediately. Words in flight are lost, and the first cycle after deassertion behaves as empty.
- Producer expectations:
  - in_data must hold while in_valid & !in_ready.
  - The stage does not require in_valid to stay high.
- Stage guarantee: out_data and out_valid remain stable while out_valid & !out_ready, except when flush or rst is asserted.

Decomposition:
- Shared package hier_leaf_pkg:
  - localparams LEAF_WIDTH_DEF = 8, LEAF_DEPTH_DEF = 4, LEAF_CNT_W_DEF = 16.
  - function clog2_plus1 for the count width.
- One natural sub-module, hier_leaf_ptr:
  - a parameterized wrapping pointer register with inc and clr inputs.
  - instantiated twice, as rd_ptr and wr_ptr.
- The storage array and flag logic stay in the top module.

Test Plan:
- Reset and fill: assert rst, then push 0x11, 0x22, 0x33, 0x44 with out_ready = 0.
  - count goes 1,2,3,4; in_ready = 0 after the 4th push.
  - out_data = 0x11 throughout.
- Drain: with the FIFO full, hold out_ready = 1 for 4 cycles.
  - out_data sequence is 0x11, 0x22, 0x33, 0x44.
  - xfer_cnt = 4, count = 0, out_valid = 0 afterwards.
- Simultaneous traffic: start with count = 2, then push and pop together for 10 cycles with incrementing data.
  - count stays 2, order is preserved, xfer_cnt += 10.
  - Pointers wrap at least twice with no corruption.
- Overflow: fill to 4, then drive in_valid with 0x55 while out_ready = 0.
  - overflow = 1 the next cycle and stays set through a later flush.
  - 0x55 never appears on out_data.
- Flush priority: with count = 3, assert flush together with in_valid and out_ready.
  - Next cycle: count = 0, out_valid = 0, xfer_cnt unchanged.
  - A following push of 0x66 is output as the next word.
- Counter wrap and async reset: set CNT_W = 4 and perform 17 pops; xfer_cnt ends at 1.
  - Then pulse rst between clock edges: all outputs return to reset values before the next edge.
